// File: rtl/fifo_arb_pkg.sv
// Shared types and default sizing for the FIFO write-port arbiter.
package fifo_arb_pkg;

  localparam int unsigned DEF_NUM_REQ   = 4;
  localparam int unsigned DEF_DATA_W    = 8;
  localparam int unsigned DEF_MAX_BURST = 4;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_BURST = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_picker.sv
// Round-robin pick: rotate the request vector so rr_ptr+1 lands at bit 0, then
// take the lowest set bit and map it back to an absolute producer index.
module rr_picker #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
  output logic                       pick_valid,
  output logic [$clog2(NUM_REQ)-1:0] pick_id
);

  localparam int unsigned ID_W = $clog2(NUM_REQ);

  logic [ID_W-1:0]    start;
  logic [NUM_REQ-1:0] rot;
  logic [ID_W-1:0]    enc;
  logic [ID_W:0]      sum;

  always_comb begin
    start = (rr_ptr == ID_W'(NUM_REQ - 1)) ? '0 : ID_W'(rr_ptr + 1'b1);
    rot   = NUM_REQ'({req, req} >> start);

    // Descending scan so the lowest rotated position wins.
    enc = '0;
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      if (rot[i]) enc = ID_W'(i);
    end

    sum = {1'b0, start} + {1'b0, enc};
    if (sum >= (ID_W + 1)'(NUM_REQ)) sum = sum - (ID_W + 1)'(NUM_REQ);

    pick_valid = |req;
    pick_id    = sum[ID_W-1:0];
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NUM_REQ producers,
// locking the winner for bursts of up to MAX_BURST words.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = DEF_NUM_REQ,
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned MAX_BURST = DEF_MAX_BURST
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]    req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic                         fifo_full,
  output logic                         fifo_wr,
  output logic [DATA_W-1:0]            fifo_din,
  output logic                         grant_valid,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id
);

  localparam int unsigned ID_W  = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

  arb_state_e       state, state_nxt;
  logic [ID_W-1:0]  owner, owner_nxt;
  logic [ID_W-1:0]  rr_ptr, rr_ptr_nxt;
  logic [CNT_W-1:0] beat_cnt, beat_cnt_nxt;

  logic               pick_valid;
  logic [ID_W-1:0]    pick_id;
  logic               own_valid;
  logic [DATA_W-1:0]  own_data;
  logic [NUM_REQ-1:0] owner_oh;

  rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .req        (req_valid),
    .rr_ptr     (rr_ptr),
    .pick_valid (pick_valid),
    .pick_id    (pick_id)
  );

  // Select the current owner's valid and data.
  always_comb begin
    own_valid = 1'b0;
    own_data  = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (owner == ID_W'(i)) begin
        own_valid = req_valid[i];
        own_data  = req_data[i*DATA_W +: DATA_W];
      end
    end
    owner_oh = NUM_REQ'(1) << owner;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ARB_IDLE;
      owner    <= '0;
      rr_ptr   <= ID_W'(NUM_REQ - 1);
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      owner    <= owner_nxt;
      rr_ptr   <= rr_ptr_nxt;
      beat_cnt <= beat_cnt_nxt;
    end
  end

  // Next state and port-facing outputs; outputs are decoded from registered
  // state so an async reset silences them immediately.
  always_comb begin
    state_nxt    = state;
    owner_nxt    = owner;
    rr_ptr_nxt   = rr_ptr;
    beat_cnt_nxt = beat_cnt;
    req_ready    = '0;
    fifo_wr      = 1'b0;
    fifo_din     = '0;
    grant_valid  = (state == ARB_BURST);
    grant_id     = owner;

    case (state)
      ARB_IDLE: begin
        if (pick_valid) begin
          owner_nxt    = pick_id;
          beat_cnt_nxt = '0;
          state_nxt    = ARB_BURST;
        end
      end

      ARB_BURST: begin
        req_ready = owner_oh & {NUM_REQ{!fifo_full}};
        fifo_wr   = own_valid & !fifo_full;
        fifo_din  = own_data;

        if (!own_valid) begin
          state_nxt  = ARB_IDLE;
          rr_ptr_nxt = owner;
        end else if (fifo_wr) begin
          beat_cnt_nxt = beat_cnt + CNT_W'(1);
          if (beat_cnt == CNT_W'(MAX_BURST - 1)) begin
            state_nxt  = ARB_IDLE;
            rr_ptr_nxt = owner;
          end
        end
        // fifo_full with owner valid: hold everything.
      end

      default: state_nxt = ARB_IDLE;
    endcase
  end

  a_no_wr_when_full: assert property (@(posedge clk) disable iff (!rst_n) fifo_full |-> !fifo_wr);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: per-cycle comparison against a
// grant-level model, plus directed scenarios pinned with literal expectations.
module tb_fifo_wr_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NR-1:0]    req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    req_ready;
  logic             fifo_full;
  logic             fifo_wr;
  logic [DW-1:0]    fifo_din;
  logic             grant_valid;
  logic [1:0]       grant_id;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .NUM_REQ   (NR),
    .DATA_W    (DW),
    .MAX_BURST (MB)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .fifo_full   (fifo_full),
    .fifo_wr     (fifo_wr),
    .fifo_din    (fifo_din),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  typedef struct {
    int cyc;
    int din;
    int gid;
  } wr_t;

  wr_t        wlog[$];
  logic [7:0] pq[NR][$];
  int         n_checks = 0;
  int         n_pass   = 0;
  int         cyc      = 0;
  bit         rnd_on   = 1'b0;
  int         rst_epoch = 0;
  int         pend_epoch = 0;
  bit         pend_wr = 1'b0;
  int         pend_din = 0;
  int         pend_gid = 0;

  // Grant-level model: who holds the port, words written in this grant,
  // and the last producer served.
  bit            m_busy  = 1'b0;
  int            m_own   = 0;
  int            m_rr    = NR - 1;
  int            m_beats = 0;
  logic [NR-1:0] acc_last = '0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
  endtask

  function automatic int rr_pick(input logic [NR-1:0] v, input int rr);
    for (int k = 1; k <= NR; k++) begin
      if (v[(rr + k) % NR]) return (rr + k) % NR;
    end
    return -1;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge rst_n) rst_epoch <= rst_epoch + 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy   <= 1'b0;
      m_own    <= 0;
      m_rr     <= NR - 1;
      m_beats  <= 0;
      acc_last <= '0;
    end else begin
      acc_last <= (m_busy && !fifo_full && req_valid[m_own]) ? NR'(1 << m_own) : '0;
      if (!m_busy) begin
        if (rr_pick(req_valid, m_rr) >= 0) begin
          m_busy  <= 1'b1;
          m_own   <= rr_pick(req_valid, m_rr);
          m_beats <= 0;
        end
      end else if (!req_valid[m_own]) begin
        m_busy <= 1'b0;
        m_rr   <= m_own;
      end else if (!fifo_full) begin
        m_beats <= m_beats + 1;
        if (m_beats + 1 == MB) begin
          m_busy <= 1'b0;
          m_rr   <= m_own;
        end
      end
    end
  end

  // Words actually written, recorded at the edge that commits them.
  always @(posedge clk) begin
    if (rst_n && pend_wr && pend_epoch == rst_epoch) wlog.push_back('{cyc, pend_din, pend_gid});
  end

  // Per-cycle compare, mid-cycle away from the active edge.
  initial begin
    logic [NR-1:0] e_rdy;
    logic          e_wr;
    logic [DW-1:0] e_din;
    forever begin
      @(negedge clk);
      #1;
      e_rdy = '0;
      if (m_busy && !fifo_full) e_rdy[m_own] = 1'b1;
      e_wr  = m_busy && req_valid[m_own] && !fifo_full;
      e_din = m_busy ? req_data[m_own*DW +: DW] : '0;
      check("grant_valid", 32'(grant_valid), 32'(m_busy));
      check("grant_id", 32'(grant_id), 32'(m_own));
      check("req_ready", 32'(req_ready), 32'(e_rdy));
      check("fifo_wr", 32'(fifo_wr), 32'(e_wr));
      check("fifo_din", 32'(fifo_din), 32'(e_din));
      pend_wr    = fifo_wr;
      pend_din   = int'(fifo_din);
      pend_gid   = int'(grant_id);
      pend_epoch = rst_epoch;
    end
  end

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      if (acc_last[i] && pq[i].size() > 0) void'(pq[i].pop_front());
      req_valid[i]          = (pq[i].size() != 0);
      req_data[i*DW +: DW]  = (pq[i].size() != 0) ? pq[i][0] : 8'h00;
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (rnd_on) begin
      for (int i = 0; i < NR; i++) begin
        if (pq[i].size() < 6 && $urandom_range(0, 7) == 0) begin
          repeat ($urandom_range(1, MB + 2)) pq[i].push_back(8'($urandom));
        end
      end
      fifo_full = ($urandom_range(0, 3) == 0);
    end
    drive();
  endtask

  task automatic wait_writes(input int n, input int bound);
    for (int c = 0; c < bound && wlog.size() < n; c++) step();
    check("wait_writes", 32'(wlog.size() >= n), 32'd1);
  endtask

  task automatic wait_idle(input int bound);
    int c;
    c = 0;
    while (c < bound && (m_busy || pq[0].size() + pq[1].size() + pq[2].size() + pq[3].size() != 0)) begin
      step();
      c++;
    end
    check("drain", 32'(c < bound), 32'd1);
    repeat (2) step();
  endtask

  task automatic do_reset();
    fifo_full = 1'b0;
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    wlog.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1);
  end

  initial begin
    int n;
    rst_n     = 1'b1;
    fifo_full = 1'b0;
    req_valid = '0;
    req_data  = '0;
    #1 rst_n = 1'b0;

    // Reset with every producer requesting.
    for (int i = 0; i < NR; i++) pq[i].push_back(8'(8'hA0 + i));
    step();
    #2;
    check("rst_fifo_wr", 32'(fifo_wr), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_grant_valid", 32'(grant_valid), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    check("rst_fifo_din", 32'(fifo_din), 32'd0);
    step();
    rst_n = 1'b1;
    wlog.delete();
    step();
    #2;
    check("first_grant_valid", 32'(grant_valid), 32'd1);
    check("first_grant_id", 32'(grant_id), 32'd0);
    wait_idle(100);
    check("first_word", 32'(wlog[0].din), 32'hA0);

    // Single producer 2, six words.
    do_reset();
    for (int k = 0; k < 6; k++) pq[2].push_back(8'(8'h10 + k));
    wait_writes(6, 60);
    if (wlog.size() >= 6) begin
      for (int k = 0; k < 6; k++) begin
        check("single_din", 32'(wlog[k].din), 32'(8'h10 + k));
        check("single_gid", 32'(wlog[k].gid), 32'd2);
      end
      for (int k = 1; k < 4; k++) check("single_gap", 32'(wlog[k].cyc - wlog[k-1].cyc), 32'd1);
      check("single_bubble", 32'(wlog[4].cyc - wlog[3].cyc), 32'd2);
      check("single_tail", 32'(wlog[5].cyc - wlog[4].cyc), 32'd1);
    end
    wait_idle(60);
    check("single_idle", 32'(grant_valid), 32'd0);

    // All producers continuously valid.
    do_reset();
    for (int i = 0; i < NR; i++)
      for (int k = 0; k < 8; k++) pq[i].push_back(8'(i * 16 + k));
    wait_writes(20, 120);
    if (wlog.size() >= 20) begin
      for (int j = 0; j < 5; j++) begin
        check("all_gid_first", 32'(wlog[4*j].gid), 32'(j % NR));
        check("all_gid_last", 32'(wlog[4*j+3].gid), 32'(j % NR));
        if (j > 0) check("all_period", 32'(wlog[4*j].cyc - wlog[4*(j-1)].cyc), 32'd5);
      end
      check("all_second_grant0", 32'(wlog[16].din), 32'h04);
    end
    wait_idle(200);

    // Full stall after beat 2 of producer 1.
    do_reset();
    for (int k = 0; k < 4; k++) pq[1].push_back(8'(8'h20 + k));
    wait_writes(2, 40);
    fifo_full = 1'b1;
    for (int s = 0; s < 3; s++) begin
      #2;
      check("stall_wr", 32'(fifo_wr), 32'd0);
      check("stall_ready", 32'(req_ready), 32'd0);
      check("stall_gid", 32'(grant_id), 32'd1);
      check("stall_gv", 32'(grant_valid), 32'd1);
      step();
    end
    fifo_full = 1'b0;
    wait_writes(4, 40);
    if (wlog.size() >= 4) begin
      check("stall_resume_gap", 32'(wlog[2].cyc - wlog[1].cyc), 32'd4);
      check("stall_last_gap", 32'(wlog[3].cyc - wlog[2].cyc), 32'd1);
      for (int k = 0; k < 4; k++) check("stall_din", 32'(wlog[k].din), 32'(8'h20 + k));
    end
    wait_idle(60);
    check("stall_total", 32'(wlog.size()), 32'd4);

    // Owner 0 drops valid after one beat; producer 3 waiting.
    do_reset();
    pq[0].push_back(8'h30);
    pq[3].push_back(8'h40);
    pq[3].push_back(8'h41);
    wait_writes(3, 40);
    if (wlog.size() >= 3) begin
      check("drop_gid0", 32'(wlog[0].gid), 32'd0);
      check("drop_din0", 32'(wlog[0].din), 32'h30);
      check("drop_gid3", 32'(wlog[1].gid), 32'd3);
      check("drop_din3", 32'(wlog[1].din), 32'h40);
      check("drop_gap", 32'(wlog[1].cyc - wlog[0].cyc), 32'd3);
      check("drop_tail", 32'(wlog[2].din), 32'h41);
    end
    wait_idle(60);

    // Async reset during beat 3.
    do_reset();
    for (int i = 0; i < NR; i++)
      for (int k = 0; k < 8; k++) pq[i].push_back(8'(i * 16 + k));
    wait_writes(2, 40);
    #3 rst_n = 1'b0;
    #1;
    check("arst_wr", 32'(fifo_wr), 32'd0);
    check("arst_ready", 32'(req_ready), 32'd0);
    check("arst_gv", 32'(grant_valid), 32'd0);
    check("arst_din", 32'(fifo_din), 32'd0);
    n = wlog.size();
    repeat (2) step();
    rst_n = 1'b1;
    check("arst_no_write", 32'(wlog.size()), 32'(n));
    wait_writes(n + 1, 40);
    if (wlog.size() > n) begin
      check("arst_regrant", 32'(wlog[n].gid), 32'd0);
      check("arst_word", 32'(wlog[n].din), 32'h02);
    end
    wait_idle(300);

    // Randomized traffic and backpressure.
    do_reset();
    rnd_on = 1'b1;
    repeat (1500) step();
    rnd_on = 1'b0;
    fifo_full = 1'b0;
    wait_idle(400);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write arbiter that shares the write port of one synchronous FIFO between `NUM_REQ` producers. Each producer uses a valid/ready handshake. The winner is locked for a burst of up to `MAX_BURST` words, which keeps FIFO contents contiguous per producer. The arbiter sits directly in front of the FIFO and drives its `wr`/`din`, using `full` as backpressure.

## Interface
Clocking and reset are fixed: one clock `clk`; reset `rst_n` is asynchronous and active-low.

Parameters:
- `NUM_REQ`, 4: number of producers (≥ 2).
- `DATA_W`, 8: word width, equal to the FIFO data width.
- `MAX_BURST`, 4: maximum words per grant (≥ 1).

Ports:
- `clk`  in  1: clock, rising edge.
- `rst_n`  in  1: asynchronous active-low reset.
- `req_valid`  in  `NUM_REQ`: producer i has a word.
- `req_data`  in  `NUM_REQ*DATA_W`: producer i's word at `[i*DATA_W +: DATA_W]`.
- `req_ready`  out  `NUM_REQ`: producer i's word is accepted this cycle.
- `fifo_full`  in  1: FIFO full flag.
- `fifo_wr`  out  1: FIFO write strobe.
- `fifo_din`  out  `DATA_W`: FIFO write data.
- `grant_valid`  out  1: a producer currently owns the port.
- `grant_id`  out  `$clog2(NUM_REQ)`: index of the owner.

## Operation
- **FSM states.** The FSM has two states, `ARB_IDLE` and `ARB_BURST`.
- **Registered state.**
  - `state`
  - `owner`
  - `rr_ptr` (last served producer)
  - `beat_cnt`, `$clog2(MAX_BURST+1)` bits
- **ARB_IDLE.**
  - If any `req_valid` is high, pick the first set bit scanning from `rr_ptr+1` upward, modulo `NUM_REQ`.
  - Register it as `owner`, clear `beat_cnt`, and go to `ARB_BURST`.
  - `fifo_full` is ignored while arbitrating.
- **ARB_BURST, combinational outputs.**
  - `req_ready[owner] = !fifo_full`.
  - `fifo_wr = req_valid[owner] & !fifo_full`.
  - `fifo_din = owner's req_data`.
  - Every other `req_ready` bit is 0.
- **Beat counting.** A beat is any cycle with `fifo_wr = 1`; `beat_cnt` increments on each beat.
- **Burst end.** Go to `ARB_IDLE` and set `rr_ptr <= owner` when either:
  - a beat occurs with `beat_cnt == MAX_BURST-1`, or
  - `req_valid[owner]` is 0 at the clock edge.
- **Full stall.**
  - While `fifo_full` is high in `ARB_BURST` with the owner's valid high, the FSM holds state, owner and `beat_cnt`.
  - `fifo_wr` and `req_ready` stay 0 for the whole stall. There is no timeout.
- **No write when full.** The arbiter never asserts `fifo_wr` while `fifo_full` is high.
- **Producer obligation.** Producers hold `req_valid` and data stable until `req_ready`.
- **Grant outputs.** `grant_valid = (state == ARB_BURST)`; `grant_id = owner`.
- **Output defaults.** Outside `ARB_BURST`: `fifo_wr = 0`, `fifo_din = 0`, `req_ready = 0`.

## Timing
- **Reset values.**
  - `state = ARB_IDLE`
  - `owner = 0`
  - `rr_ptr = NUM_REQ-1`, so producer 0 has first priority
  - `beat_cnt = 0`
- **Outputs during reset.** All outputs are 0: `req_ready`, `fifo_wr`, `fifo_din`, `grant_valid`, `grant_id`.
- **Request latency.** A request seen in `ARB_IDLE` at edge k gives `ARB_BURST` after edge k. The first word is written at edge k+1.
- **Bubble between grants.** There is exactly one `ARB_IDLE` cycle between consecutive grants. A full unstalled `MAX_BURST` burst therefore occupies `MAX_BURST+1` cycles.
- **Accept timing.** The handshake is zero-latency: a word is accepted at the edge where `req_valid & req_ready`.
- **Reset mid-burst.**
  - `fifo_wr` and `req_ready` drop immediately (asynchronously).
  - The word presented in that cycle is not written.
  - After release, arbitration restarts from producer 0.
- **Simultaneous events.** A burst's last beat and the owner dropping valid in the same cycle cause a single transition to `ARB_IDLE`.

## Structure
- **Shared package `fifo_arb_pkg`.** Holds the `arb_state_e` enum (`ARB_IDLE`, `ARB_BURST`) and the default parameter constants.
- **Sub-module `rr_picker`.** Purely combinational.
  - Inputs: request vector and `rr_ptr`.
  - Outputs: `pick_valid` and `pick_id`.
  - Implemented as a rotate-then-priority-encode.

## Test plan
All scenarios use `NUM_REQ=4`, `DATA_W=8`, `MAX_BURST=4`.
- **Reset.** Assert `rst_n=0` with all `req_valid` high → every output is 0 and `grant_valid=0`. After release, the first grant goes to `grant_id=0`.
- **Single producer.** Producer 2 supplies 0x10..0x15 with `fifo_full=0` → writes 0x10–0x13 on 4 consecutive cycles, then 1 idle cycle, then a re-grant to 2 that writes 0x14 and 0x15, then `ARB_IDLE`.
- **All producers.** All 4 producers hold `req_valid` continuously → grant order 0,1,2,3,0, each grant exactly 4 beats, a period of 5 cycles per grant.
- **Full stall.** Raise `fifo_full` for 3 cycles after beat 2 of producer 1 → `fifo_wr=0` and `req_ready=0` for 3 cycles, `grant_id` holds 1, the burst resumes, and the total is 4 beats.
- **Owner drops valid.** Producer 0 owns the port and drops valid after 1 beat while producer 3 is valid → `ARB_IDLE` next cycle, then a grant to 3 (1 and 2 are not requesting).
- **Async reset mid-burst.** Pulse `rst_n` low mid-edge during beat 3 → `fifo_wr` falls in the same cycle with no write. After release, the grant order restarts at 0.
